iob_cache_line_fetch: RTL and testbench



---
 rtl/iob_cache_line_fetch_pkg.sv | 28 ++
 rtl/iob_cache_fetch_cnt.sv | 28 ++
 rtl/iob_cache_line_fetch.sv | 130 +++++++++++++
 tb/tb_iob_cache_line_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_line_fetch_pkg.sv
// Shared types and width helpers for the cache line fetch engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package iob_cache_line_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_t;

  // Byte-offset bits inside one bus word.
  function automatic int boff_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index bits inside one cache line.
  function automatic int woff_w(input int words);
    return $clog2(words);
  endfunction

  // One extra bit so a counter can hold the value WORDS without wrapping.
  function automatic int cnt_w(input int words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/iob_cache_fetch_cnt.sv
// Up-counter with synchronous clear and enable, frozen while cke is low.
// Latency: new value visible one clock after clr/en.
// Backpressure: none; the owner decides when to count.
// Ports: clk, arst_n (async active-low), cke, clr (priority over en), en, cnt.
module iob_cache_fetch_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         cke,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (cke) begin
      if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/iob_cache_line_fetch.sv
// IOb initiator that reads one full cache line word by word and streams it into line storage.
// Latency: first request the cycle after accept; done WORDS+2 cycles after accept with ready=1, rvalid +1.
// Backpressure: iob_ready_i low holds address/valid; fetch_ready_o low while a line is in flight.
// Ports: fetch_* (controller side), line_* (data memory write port), iob_* (next-level memory),
//        cke_i freezes all state, err_o flags responses that arrive with nothing outstanding.
module iob_cache_line_fetch
  import iob_cache_line_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     cke_i,
  input  logic                     fetch_req_i,
  input  logic [ADDR_W-1:0]        fetch_addr_i,
  output logic                     fetch_ready_o,
  output logic                     fetch_done_o,
  output logic                     err_o,
  output logic                     line_wen_o,
  output logic [$clog2(WORDS)-1:0] line_widx_o,
  output logic [DATA_W-1:0]        line_wdata_o,
  output logic                     iob_valid_o,
  output logic [ADDR_W-1:0]        iob_addr_o,
  output logic [DATA_W-1:0]        iob_wdata_o,
  output logic [DATA_W/8-1:0]      iob_wstrb_o,
  input  logic                     iob_ready_i,
  input  logic                     iob_rvalid_i,
  input  logic [DATA_W-1:0]        iob_rdata_i
);

  localparam int BOFF_W = boff_w(DATA_W);
  localparam int WOFF_W = woff_w(WORDS);
  localparam int CNT_W  = cnt_w(WORDS);

  // Clears the word and byte offset so the base points at the first word of the line.
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << (WOFF_W + BOFF_W)) - ADDR_W'(1));
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic              err_q;
  logic [CNT_W-1:0]  req_cnt, rsp_cnt;

  logic fetch_acc, req_acc, rsp_open, rsp_acc, rsp_spur;

  assign fetch_acc = cke_i && (state_q == ST_IDLE) && fetch_req_i;
  assign req_acc   = cke_i && (state_q == ST_REQ) && iob_ready_i;
  // A response is only legal while some accepted request is still unanswered.
  assign rsp_open  = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && (rsp_cnt < req_cnt);
  assign rsp_acc   = cke_i && iob_rvalid_i && rsp_open;
  assign rsp_spur  = cke_i && iob_rvalid_i && !rsp_open;

  iob_cache_fetch_cnt #(.W(CNT_W)) u_req_cnt (
    .clk    (clk_i),
    .arst_n (arst_n_i),
    .cke    (cke_i),
    .clr    (fetch_acc),
    .en     (req_acc),
    .cnt    (req_cnt)
  );

  iob_cache_fetch_cnt #(.W(CNT_W)) u_rsp_cnt (
    .clk    (clk_i),
    .arst_n (arst_n_i),
    .cke    (cke_i),
    .clr    (fetch_acc),
    .en     (rsp_acc),
    .cnt    (rsp_cnt)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      if (fetch_acc) begin
        base_q <= fetch_addr_i & LINE_MASK;
      end
      // A stray response in the accepting cycle still gets reported.
      if (rsp_spur) begin
        err_q <= 1'b1;
      end else if (fetch_acc) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_ready_o = 1'b0;
    fetch_done_o  = 1'b0;
    iob_valid_o   = 1'b0;
    iob_addr_o    = '0;
    unique case (state_q)
      ST_IDLE: begin
        fetch_ready_o = 1'b1;
        if (fetch_req_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        iob_valid_o = 1'b1;
        // Word offset is ORed into bits that the base has cleared, so no carry.
        iob_addr_o  = base_q | (ADDR_W'(req_cnt[WOFF_W-1:0]) << BOFF_W);
        if (iob_ready_i && (req_cnt == CNT_LAST)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Leave as soon as the last response is being taken, not a cycle later.
        if ((rsp_cnt == CNT_FULL) || (rsp_acc && (rsp_cnt == CNT_LAST))) state_d = ST_DONE;
      end
      ST_DONE: begin
        fetch_done_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_o        = err_q;
  assign line_wen_o   = rsp_acc;
  assign line_widx_o  = rsp_cnt[WOFF_W-1:0];
  assign line_wdata_o = rsp_acc ? iob_rdata_i : '0;
  assign iob_wdata_o  = '0;
  assign iob_wstrb_o  = '0;

endmodule

// File: tb/tb_iob_cache_line_fetch.sv
// Bench for iob_cache_line_fetch: memory responder with programmable latency plus a line-level model.
// Latency: model expects done once all WORDS responses have landed.
// Backpressure: bench drives iob_ready_i and cke_i windows per scenario.
module tb_iob_cache_line_fetch;

  localparam int WORDS      = 4;
  localparam int BYTES      = 4;
  localparam int LINE_BYTES = WORDS * BYTES;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        cke_i;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_ready_o;
  logic        fetch_done_o;
  logic        err_o;
  logic        line_wen_o;
  logic [1:0]  line_widx_o;
  logic [31:0] line_wdata_o;
  logic        iob_valid_o;
  logic [31:0] iob_addr_o;
  logic [31:0] iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_ready_i;
  logic        iob_rvalid_i;
  logic [31:0] iob_rdata_i;

  iob_cache_line_fetch #(.ADDR_W(32), .DATA_W(32), .WORDS(WORDS)) dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .cke_i        (cke_i),
    .fetch_req_i  (fetch_req_i),
    .fetch_addr_i (fetch_addr_i),
    .fetch_ready_o(fetch_ready_o),
    .fetch_done_o (fetch_done_o),
    .err_o        (err_o),
    .line_wen_o   (line_wen_o),
    .line_widx_o  (line_widx_o),
    .line_wdata_o (line_wdata_o),
    .iob_valid_o  (iob_valid_o),
    .iob_addr_o   (iob_addr_o),
    .iob_wdata_o  (iob_wdata_o),
    .iob_wstrb_o  (iob_wstrb_o),
    .iob_ready_i  (iob_ready_i),
    .iob_rvalid_i (iob_rvalid_i),
    .iob_rdata_i  (iob_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory contents: word index within the line in the low byte, scenario tag on top.
  int tag = 0;
  function automatic logic [31:0] data_of(input logic [31:0] addr);
    return (32'(tag) << 24) | (32'hA0 + ((addr / BYTES) % WORDS));
  endfunction

  // Responder: answers accepted reads in order, cur_lat cycles after acceptance.
  int          cyc = 0;
  int          cur_lat = 1;
  logic        spur = 1'b0;
  int          q_due[$];
  logic [31:0] q_addr[$];

  always @(posedge clk_i) cyc++;

  always @(posedge clk_i) begin
    #2;
    if (q_due.size() > 0 && q_due[0] <= cyc && cke_i) begin
      iob_rvalid_i = 1'b1;
      iob_rdata_i  = data_of(q_addr[0]);
      void'(q_due.pop_front());
      void'(q_addr.pop_front());
    end else if (spur) begin
      iob_rvalid_i = 1'b1;
      iob_rdata_i  = 32'hDEAD_BEEF;
    end else begin
      iob_rvalid_i = 1'b0;
      iob_rdata_i  = '0;
    end
  end

  // Line-level model: a fetch is busy from acceptance until its done cycle; it owes WORDS
  // requests in address order and WORDS writes in index order.
  logic        m_busy = 1'b0;
  int          m_nreq = 0;
  int          m_nrsp = 0;
  logic [31:0] m_base = '0;
  logic        m_err  = 1'b0;

  always @(negedge clk_i) begin
    logic e_done, e_valid, ok, e_wen;
    if (!arst_n_i) begin
      chk("reset_ready", fetch_ready_o, 1);
      chk("reset_valid", iob_valid_o, 0);
      chk("reset_done", fetch_done_o, 0);
      chk("reset_wen", line_wen_o, 0);
      chk("reset_err", err_o, 0);
      m_busy = 1'b0; m_nreq = 0; m_nrsp = 0; m_base = '0; m_err = 1'b0;
    end else begin
      e_done  = m_busy && (m_nrsp == WORDS);
      e_valid = m_busy && !e_done && (m_nreq < WORDS);
      ok      = m_busy && !e_done && (m_nrsp < m_nreq);
      e_wen   = cke_i && iob_rvalid_i && ok;
      chk("m_ready", fetch_ready_o, !m_busy);
      chk("m_done", fetch_done_o, e_done);
      chk("m_valid", iob_valid_o, e_valid);
      chk("m_wen", line_wen_o, e_wen);
      chk("m_err", err_o, m_err);
      if (e_valid) begin
        chk("m_addr", iob_addr_o, m_base + 32'(m_nreq * BYTES));
        chk("m_wrd0", {iob_wstrb_o, iob_wdata_o}, 0);
      end
      if (e_wen) begin
        chk("m_widx", line_widx_o, m_nrsp);
        chk("m_wdata", line_wdata_o, data_of(m_base + 32'(m_nrsp * BYTES)));
      end
      if (cke_i) begin
        if (iob_valid_o && iob_ready_i) begin
          q_due.push_back(cyc + cur_lat);
          q_addr.push_back(iob_addr_o);
        end
        if (!m_busy) begin
          if (fetch_req_i) begin
            m_busy = 1'b1; m_nreq = 0; m_nrsp = 0; m_err = 1'b0;
            m_base = fetch_addr_i - (fetch_addr_i % LINE_BYTES);
          end
        end else if (e_done) begin
          m_busy = 1'b0;
        end else begin
          if (e_valid && iob_ready_i) m_nreq++;
          if (e_wen) m_nrsp++;
        end
        if (iob_rvalid_i && !ok) m_err = 1'b1;
      end
    end
  end

  // One fetch scenario over a fixed 40-cycle window; k counts cycles from the accept cycle.
  task automatic run_fetch(input logic [31:0] addr, input int lat,
                           input int rlo_a, input int rlo_b, input int clo_a, input int clo_b,
                           input int inj_k, input logic [31:0] inj_addr,
                           input int rst_k, input int exp_done, input logic pin1,
                           input int pin_k, input logic [31:0] pin_addr);
    int done_at = -1;
    int ndone   = 0;
    cur_lat = lat;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i); #1;
      fetch_req_i  = (k == 0) || (k == inj_k);
      fetch_addr_i = (k == inj_k) ? inj_addr : addr;
      iob_ready_i  = !(k >= rlo_a && k <= rlo_b);
      cke_i        = !(k >= clo_a && k <= clo_b);
      if (k == rst_k) begin
        arst_n_i = 1'b0;
        #1;
        chk("rst_async_valid", iob_valid_o, 0);
        chk("rst_async_ready", fetch_ready_o, 1);
      end
      if (k == rst_k + 1) arst_n_i = 1'b1;
      @(negedge clk_i);
      if (fetch_done_o) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (k == 1) chk("err_clear", err_o, 0);
      if (k == pin_k) begin
        chk("pin_valid", iob_valid_o, 1);
        chk("pin_addr", iob_addr_o, pin_addr);
      end
      if (rst_k >= 0 && k == rst_k + 3) chk("rst_spur_err", err_o, 1);
      if (pin1) begin
        if (k >= 1 && k <= 4) chk("t1_addr", iob_addr_o, 32'h1000_0010 + 32'(4 * (k - 1)));
        if (k >= 2 && k <= 5) begin
          chk("t1_wen", line_wen_o, 1);
          chk("t1_widx", line_widx_o, k - 2);
          chk("t1_wdata", line_wdata_o, 32'hA0 + 32'(k - 2));
        end
        if (k == 7) chk("t1_ready", fetch_ready_o, 1);
        if (k == 7) chk("t1_err", err_o, 0);
      end
    end
    fetch_req_i = 1'b0;
    if (rst_k < 0) begin
      chk("done_cycle", done_at, exp_done);
      chk("done_count", ndone, 1);
    end
  endtask

  initial begin
    arst_n_i     = 1'b0;
    cke_i        = 1'b1;
    fetch_req_i  = 1'b0;
    fetch_addr_i = '0;
    iob_ready_i  = 1'b1;
    iob_rvalid_i = 1'b0;
    iob_rdata_i  = '0;
    repeat (3) @(posedge clk_i);
    #1 arst_n_i = 1'b1;

    // Basic line fetch, pinned cycle by cycle.
    tag = 0;
    run_fetch(32'h1000_0014, 1, -1, -1, -1, -1, -1, 0, -1, 6, 1'b1, -1, 0);
    // Request backpressure holds the second address.
    tag = 1;
    run_fetch(32'h1000_0014, 1, 2, 4, -1, -1, -1, 0, -1, 9, 1'b0, 3, 32'h1000_0014);
    // Three-cycle response latency overlapping requests; new fetch during WAIT ignored.
    tag = 2;
    run_fetch(32'h1000_0014, 3, -1, -1, -1, -1, 6, 32'h2000_0000, -1, 8, 1'b0, -1, 0);
    // Clock enable low for two cycles in REQ freezes address and counters.
    tag = 3;
    run_fetch(32'h1000_0014, 1, -1, -1, 2, 3, -1, 0, -1, 8, 1'b0, 3, 32'h1000_0014);
    // Reset mid-fetch; late responses afterwards are spurious.
    tag = 4;
    run_fetch(32'h1000_0014, 3, -1, -1, -1, -1, -1, 0, 3, 0, 1'b0, -1, 0);

    // Stray rvalid while idle: no write, error raised.
    @(posedge clk_i); #1 spur = 1'b1;
    @(negedge clk_i);
    chk("spur_wen", line_wen_o, 0);
    @(posedge clk_i); #1 spur = 1'b0;
    @(negedge clk_i);
    chk("spur_err", err_o, 1);

    // Next accepted fetch clears the error; line at the top of a 16-byte block.
    tag = 5;
    run_fetch(32'h3000_003C, 2, -1, -1, -1, -1, -1, 0, -1, 7, 1'b0, 1, 32'h3000_0030);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
